// File: rtl/cc_psr_pkg.sv
// ---------------------------------------------------------------------------
// cc_psr_pkg
// Shared constants for the PSR / branch-condition unit.
//   COND_*      : the 16 SPARC/ARC branch condition encodings
//   ICC_*       : bit positions of N/Z/V/C inside the 4-bit icc field
//   PSR_ICC_LSB : default bit position of C inside the 32-bit PSR word
// ---------------------------------------------------------------------------
package cc_psr_pkg;

    localparam int ICC_WIDTH   = 4;
    localparam int ICC_N       = 3;
    localparam int ICC_Z       = 2;
    localparam int ICC_V       = 1;
    localparam int ICC_C       = 0;
    localparam int PSR_ICC_LSB = 20;

    // Lower half: the base predicates. Upper half: their complements,
    // with "always" being the complement of "never".
    localparam logic [3:0] COND_NEVER  = 4'b0000;
    localparam logic [3:0] COND_E      = 4'b0001;
    localparam logic [3:0] COND_LE     = 4'b0010;
    localparam logic [3:0] COND_L      = 4'b0011;
    localparam logic [3:0] COND_LEU    = 4'b0100;
    localparam logic [3:0] COND_CS     = 4'b0101;
    localparam logic [3:0] COND_NEG    = 4'b0110;
    localparam logic [3:0] COND_VS     = 4'b0111;
    localparam logic [3:0] COND_ALWAYS = 4'b1000;
    localparam logic [3:0] COND_NE     = 4'b1001;
    localparam logic [3:0] COND_G      = 4'b1010;
    localparam logic [3:0] COND_GE     = 4'b1011;
    localparam logic [3:0] COND_GU     = 4'b1100;
    localparam logic [3:0] COND_CC     = 4'b1101;
    localparam logic [3:0] COND_POS    = 4'b1110;
    localparam logic [3:0] COND_VC     = 4'b1111;

endpackage

// File: rtl/cc_psr_cond_unit_if.sv
// ---------------------------------------------------------------------------
// cc_psr_cond_unit_if
// Bundles the ALU flag inputs, the PSR bus port and the condition request /
// response handshake of cc_psr_cond_unit.
//   master : the environment (ALU, bus, microsequencer) driving the unit
//   slave  : the cc_psr_cond_unit itself
// ---------------------------------------------------------------------------
interface cc_psr_cond_unit_if #(
    parameter int DATAWIDTH_BUS  = 32,
    parameter int DATAWIDTH_COND = 4
);

    logic                      CC_PSR_overflow_InLow;
    logic                      CC_PSR_carry_InLow;
    logic                      CC_PSR_negative_InLow;
    logic                      CC_PSR_zero_InLow;
    logic                      CC_PSR_SetCode_In;
    logic                      CC_PSR_write_In;
    logic [DATAWIDTH_BUS-1:0]  CC_PSR_data_InBus;
    logic [DATAWIDTH_BUS-1:0]  CC_PSR_data_OutBus;
    logic [DATAWIDTH_COND-1:0] CC_PSR_cond_InBus;
    logic                      CC_PSR_reqValid_In;
    logic                      CC_PSR_reqReady_Out;
    logic                      CC_PSR_respValid_Out;
    logic                      CC_PSR_respReady_In;
    logic                      CC_PSR_taken_Out;
    logic                      CC_PSR_stickyOverflow_Out;

    modport master (
        output CC_PSR_overflow_InLow,
        output CC_PSR_carry_InLow,
        output CC_PSR_negative_InLow,
        output CC_PSR_zero_InLow,
        output CC_PSR_SetCode_In,
        output CC_PSR_write_In,
        output CC_PSR_data_InBus,
        input  CC_PSR_data_OutBus,
        output CC_PSR_cond_InBus,
        output CC_PSR_reqValid_In,
        input  CC_PSR_reqReady_Out,
        input  CC_PSR_respValid_Out,
        output CC_PSR_respReady_In,
        input  CC_PSR_taken_Out,
        input  CC_PSR_stickyOverflow_Out
    );

    modport slave (
        input  CC_PSR_overflow_InLow,
        input  CC_PSR_carry_InLow,
        input  CC_PSR_negative_InLow,
        input  CC_PSR_zero_InLow,
        input  CC_PSR_SetCode_In,
        input  CC_PSR_write_In,
        input  CC_PSR_data_InBus,
        output CC_PSR_data_OutBus,
        input  CC_PSR_cond_InBus,
        input  CC_PSR_reqValid_In,
        output CC_PSR_reqReady_Out,
        output CC_PSR_respValid_Out,
        input  CC_PSR_respReady_In,
        output CC_PSR_taken_Out,
        output CC_PSR_stickyOverflow_Out
    );

endinterface

// File: rtl/cc_cond_eval.sv
// ---------------------------------------------------------------------------
// cc_cond_eval
// Combinational branch-condition evaluator.
//   icc_i   : {N,Z,V,C} condition codes
//   cond_i  : 4-bit SPARC/ARC condition field
//   taken_o : 1 when the condition holds for icc_i
// ---------------------------------------------------------------------------
module cc_cond_eval
    import cc_psr_pkg::*;
(
    input  logic [ICC_WIDTH-1:0] icc_i,
    input  logic [3:0]           cond_i,
    output logic                 taken_o
);

    logic n, z, v, c;
    logic basePredicate;

    assign n = icc_i[ICC_N];
    assign z = icc_i[ICC_Z];
    assign v = icc_i[ICC_V];
    assign c = icc_i[ICC_C];

    // Only the low three bits select a predicate; bit 3 inverts it. This
    // covers "always" too, since it is the inverse of "never".
    always_comb begin
        basePredicate = 1'b0;
        case (cond_i[2:0])
            COND_NEVER[2:0]: basePredicate = 1'b0;
            COND_E[2:0]:     basePredicate = z;
            COND_LE[2:0]:    basePredicate = z | (n ^ v);
            COND_L[2:0]:     basePredicate = n ^ v;
            COND_LEU[2:0]:   basePredicate = c | z;
            COND_CS[2:0]:    basePredicate = c;
            COND_NEG[2:0]:   basePredicate = n;
            COND_VS[2:0]:    basePredicate = v;
            default:         basePredicate = 1'b0;
        endcase
    end

    assign taken_o = cond_i[3] ^ basePredicate;

endmodule

// File: rtl/cc_psr_cond_unit.sv
// ---------------------------------------------------------------------------
// cc_psr_cond_unit
// Holds the processor status register (only the icc field is implemented),
// captures the ALU's active-low flags on set-code, supports PSR bus writes,
// and answers branch-condition requests through a valid/ready pipe with a
// single response register.
//   CC_PSR_CLOCK_50     : clock, all state on rising edge
//   CC_PSR_RESET_InHigh : synchronous reset, active high
//   bus (slave)         : flags, PSR bus port, request/response handshake
// ---------------------------------------------------------------------------
module cc_psr_cond_unit
    import cc_psr_pkg::*;
#(
    parameter int DATAWIDTH_BUS  = 32,
    parameter int DATAWIDTH_COND = 4,
    parameter int PSR_ICC_LSB    = cc_psr_pkg::PSR_ICC_LSB
)(
    input  logic               CC_PSR_CLOCK_50,
    input  logic               CC_PSR_RESET_InHigh,
    cc_psr_cond_unit_if.slave  bus
);

    logic [ICC_WIDTH-1:0]     icc_q, icc_d;
    logic                     sticky_q, sticky_d;
    logic                     respValid_q, respValid_d;
    logic                     taken_q, taken_d;
    logic                     reqReady;
    logic                     accept;
    logic                     evalTaken;
    logic [DATAWIDTH_BUS-1:0] psrWord;

    // Next icc: a bus write outranks a flag capture; otherwise hold.
    // Requests evaluate against this next value so a flag-setting op and a
    // dependent branch may arrive in the same cycle.
    always_comb begin
        icc_d    = icc_q;
        sticky_d = sticky_q;
        if (bus.CC_PSR_write_In) begin
            icc_d    = bus.CC_PSR_data_InBus[PSR_ICC_LSB +: ICC_WIDTH];
            sticky_d = 1'b0;
        end else if (bus.CC_PSR_SetCode_In) begin
            icc_d    = {~bus.CC_PSR_negative_InLow, ~bus.CC_PSR_zero_InLow,
                        ~bus.CC_PSR_overflow_InLow, ~bus.CC_PSR_carry_InLow};
            sticky_d = sticky_q | ~bus.CC_PSR_overflow_InLow;
        end
    end

    cc_cond_eval u_cond_eval (
        .icc_i   (icc_d),
        .cond_i  (bus.CC_PSR_cond_InBus),
        .taken_o (evalTaken)
    );

    // One response slot: free when empty or being drained this cycle.
    always_comb begin
        reqReady    = ~respValid_q | bus.CC_PSR_respReady_In;
        accept      = bus.CC_PSR_reqValid_In & reqReady;
        respValid_d = respValid_q;
        taken_d     = taken_q;
        if (accept) begin
            respValid_d = 1'b1;
            taken_d     = evalTaken;
        end else if (respValid_q & bus.CC_PSR_respReady_In) begin
            respValid_d = 1'b0;
        end
    end

    always_ff @(posedge CC_PSR_CLOCK_50) begin
        if (CC_PSR_RESET_InHigh) begin
            icc_q       <= '0;
            sticky_q    <= 1'b0;
            respValid_q <= 1'b0;
            taken_q     <= 1'b0;
        end else begin
            icc_q       <= icc_d;
            sticky_q    <= sticky_d;
            respValid_q <= respValid_d;
            taken_q     <= taken_d;
        end
    end

    // All PSR bits outside the icc field read as zero.
    always_comb begin
        psrWord                            = '0;
        psrWord[PSR_ICC_LSB +: ICC_WIDTH]  = icc_q;
    end

    assign bus.CC_PSR_data_OutBus        = psrWord;
    assign bus.CC_PSR_reqReady_Out       = reqReady;
    assign bus.CC_PSR_respValid_Out      = respValid_q;
    assign bus.CC_PSR_taken_Out          = taken_q;
    assign bus.CC_PSR_stickyOverflow_Out = sticky_q;

endmodule
